// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the instruction fetch path.
// Fetch FSM encoding, word geometry and the skid FIFO entry layout.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_SPACE,
    FLUSH
  } fetch_state_t;

  localparam int INST_W       = 16;
  localparam int WORD_W       = 32;
  localparam int FETCH_STRIDE = 4;

  typedef struct packed {
    logic              skip_lo;
    logic [INST_W-1:0] hi;
    logic [INST_W-1:0] lo;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Skid FIFO holding fetched words plus their skip-low tag.
// Synchronous clear, simultaneous push/pop, head visible combinationally.
module fetch_skid_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch writer: one outstanding word read, skid FIFO toward the prefetch buffer.
// Redirects flush queued words and drop any response still in flight.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              buf_full,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              write,
  output logic [WORD_W-1:0] ex_inst,
  output logic              ex_skip_lo
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [WORD_W-1:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};
  localparam logic [CW-1:0]     FULL       = CW'(DEPTH);
  localparam logic [WORD_W-1:0] STRIDE     = WORD_W'(FETCH_STRIDE);

  fetch_state_t      state;
  logic [WORD_W-1:0] target;
  logic [WORD_W-1:0] redirect_addr;
  logic              skip_pending;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  fetch_entry_t      entry;
  logic              unused;

  assign unused        = redirect_pc[0];
  assign redirect_addr = {redirect_pc[31:2], 2'b00};
  assign write         = !fifo_empty && !buf_full && !redirect;
  assign pop           = write;
  assign push          = (state == REQ) && mem_ack && !redirect;
  assign count_next    = fifo_count + CW'(push) - CW'(pop);

  assign entry = '{
    skip_lo: skip_pending,
    hi:      mem_rdata[31:16],
    lo:      mem_rdata[15:0]
  };

  fetch_entry_t head;

  fetch_skid_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign ex_inst    = {head.hi, head.lo};
  assign ex_skip_lo = head.skip_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= RESET_ADDR;
      target       <= RESET_ADDR;
      skip_pending <= 1'b0;
    end else if (redirect) begin
      skip_pending <= redirect_pc[1];
      target       <= redirect_addr;
      mem_req      <= 1'b1;
      // An unanswered request must complete at its old address first.
      if ((state == REQ || state == FLUSH) && !mem_ack) begin
        state <= FLUSH;
      end else begin
        state    <= REQ;
        mem_addr <= redirect_addr;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state   <= REQ;
          mem_req <= 1'b1;
        end
        REQ: begin
          if (mem_ack) begin
            skip_pending <= 1'b0;
            mem_addr     <= mem_addr + STRIDE;
            if (count_next < FULL) begin
              state   <= REQ;
              mem_req <= 1'b1;
            end else begin
              state   <= WAIT_SPACE;
              mem_req <= 1'b0;
            end
          end
        end
        WAIT_SPACE: begin
          if (fifo_count < FULL) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        FLUSH: begin
          if (mem_ack) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= target;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit against a fetch-stream model.
// Expected stream: words of memf() from the current PC onward, first tagged by PC bit 1.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          WINDOW   = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        buf_full = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        write;
  logic [31:0] ex_inst;
  logic        ex_skip_lo;

  int checks   = 0;
  int failures = 0;
  int n_writes = 0;
  bit rand_lat = 0;

  logic [32:0] sb[$];

  inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .buf_full    (buf_full),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .write       (write),
    .ex_inst     (ex_inst),
    .ex_skip_lo  (ex_skip_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Expected future output stream from a given fetch PC.
  task automatic load_window(input logic [31:0] pc);
    logic [31:0] a;
    logic        s;
    a = {pc[31:2], 2'b00};
    s = pc[1];
    sb.delete();
    for (int i = 0; i < WINDOW; i++) begin
      sb.push_back({s, memf(a)});
      a = a + 32'd4;
      s = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = pc;
    load_window(pc);
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  // Memory: one response per request, latency fixed at 2 or random 0..3.
  initial begin
    int cnt;
    bit busy;
    busy = 0;
    cnt  = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (rst) begin
        busy = 0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1;
          cnt  = rand_lat ? int'($urandom_range(0, 3)) : 2;
        end
        if (cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = memf(mem_addr);
          busy      = 0;
        end else begin
          cnt--;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every write, checks request holding.
  initial begin
    logic [32:0] e;
    logic        open_req;
    logic [31:0] open_addr;
    open_req  = 0;
    open_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        open_req = 0;
      end else begin
        if (write) begin
          n_writes++;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty got=%h skip=%b expected=none",
                     ex_inst, ex_skip_lo);
          end else begin
            e = sb.pop_front();
            if ({ex_skip_lo, ex_inst} !== e) begin
              failures++;
              $display("FAIL write_word got=%b_%h expected=%b_%h",
                       ex_skip_lo, ex_inst, e[32], e[31:0]);
            end
          end
        end
        if (open_req) begin
          checks++;
          if (!mem_req || mem_addr !== open_addr) begin
            failures++;
            $display("FAIL req_hold got=%b/%h expected=1/%h",
                     mem_req, mem_addr, open_addr);
          end
        end
        if (mem_req) begin
          checks++;
          if (mem_addr[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL addr_align got=%h expected=xxxxxxx0", mem_addr);
          end
        end
        open_req  = mem_req && !mem_ack;
        open_addr = mem_addr;
      end
    end
  end

  initial begin
    logic [31:0] pc;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, {RESET_PC[31:2], 2'b00});
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_ex_inst", ex_inst, 32'd0);
    chk("rst_skip", 32'(ex_skip_lo), 32'd0);
    load_window(RESET_PC);
    rst = 1'b0;

    repeat (30) @(posedge clk);
    #1;
    chk("progress_after_reset", 32'(n_writes >= 5), 32'd1);

    // Back-pressure until the FIFO fills and requests stop.
    buf_full = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("wait_space_req", 32'(mem_req), 32'd0);
    chk("wait_space_write", 32'(write), 32'd0);

    // Asynchronous reset mid-cycle, no clock edge before checking.
    #2;
    rst      = 1'b1;
    buf_full = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_addr", mem_addr, {RESET_PC[31:2], 2'b00});
    chk("arst_write", 32'(write), 32'd0);
    chk("arst_ex_inst", ex_inst, 32'd0);
    chk("arst_skip", 32'(ex_skip_lo), 32'd0);
    load_window(RESET_PC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    repeat (12) @(posedge clk);
    do_redirect(32'h0000_0102);
    repeat (20) @(posedge clk);
    do_redirect(32'hFFFF_FFFC);
    repeat (20) @(posedge clk);
    do_redirect(32'hFFFF_FFFA);
    repeat (20) @(posedge clk);

    rand_lat = 1;
    repeat (3000) begin
      @(posedge clk); #1;
      buf_full = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 39) == 0) begin
        pc = $urandom;
        if ($urandom_range(0, 3) == 0)
          pc = {29'h1FFF_FFFF, pc[2:0]};
        redirect    = 1'b1;
        redirect_pc = pc;
        load_window(pc);
      end else begin
        redirect = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    buf_full = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("progress_total", 32'(n_writes >= 500), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Writer side of the fetch path.
- Issues 32-bit word reads to instruction memory and buffers the returned words in a small skid FIFO.
- Pushes each word, holding two 16-bit instructions (low halfword first), into the prefetch buffer with a write strobe.
- Handles back-pressure from the prefetch buffer and redirects from jump/branch resolution.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset (bits [1:0] ignored).
- DEPTH, 2, skid FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- redirect  in  1  one-cycle pulse: discard queued/in-flight words, restart at redirect_pc.
- redirect_pc  in  32  byte address of the new target; bit [1] selects the halfword.
- buf_full  in  1  prefetch buffer cannot accept a word this cycle.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  32  word-aligned byte address; bits [1:0] are always 0.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  [15:0] = instruction at addr, [31:16] = instruction at addr+2.
- write  out  1  word valid toward the prefetch buffer.
- ex_inst  out  32  word toward the prefetch buffer.
- ex_skip_lo  out  1  qualified by write; ex_inst[15:0] must be discarded.

Behaviour:
- Reset values while rst is high:
  - state = IDLE, mem_req = 0, mem_addr = {RESET_PC[31:2], 2'b00}.
  - FIFO empty, write = 0, ex_inst = 0, ex_skip_lo = 0, skip_pending = 0.
  - Reset mid-transaction abandons the outstanding request; memory tolerates this.
- States:
  - IDLE: always moves to REQ on the next clock.
  - REQ: mem_req = 1.
  - WAIT_SPACE: mem_req = 0.
  - FLUSH: mem_req = 1; the response will be discarded.
- Request rule:
  - Exactly one request outstanding at most.
  - mem_req and mem_addr are held stable from assertion until the mem_ack cycle.
  - A request is raised only when fifo_count < DEPTH, so a returned word always has a slot.
- REQ with mem_ack and no redirect:
  - Push mem_rdata with tag skip_pending, then clear skip_pending.
  - mem_addr += 4; wraps from 32'hFFFF_FFFC to 0.
  - Next state is REQ if the post-push/pop count < DEPTH, else WAIT_SPACE.
- WAIT_SPACE: moves to REQ in the cycle after count drops below DEPTH.
- Drain side:
  - write = !fifo_empty && !buf_full (combinational from registered FIFO state).
  - ex_inst and ex_skip_lo come from the FIFO head.
  - A pop occurs when write is high; 0-cycle latency from head to output.
  - Push and pop in the same cycle leave count unchanged.
  - Minimum latency mem_ack → write is 1 cycle (word registered into the FIFO).
- Redirect (highest priority, checked every state):
  - FIFO is cleared; write is forced to 0 in the redirect cycle.
  - mem_addr loads at the next request boundary: {redirect_pc[31:2], 2'b00}.
  - skip_pending <= redirect_pc[1].
  - REQ without ack this cycle: go to FLUSH; keep the old mem_addr until ack, drop that data, then load the new address and go to REQ.
  - REQ with ack this cycle: drop the data; load the new address; go to REQ next cycle.
  - FLUSH: update the pending target only; stay in FLUSH.
  - IDLE or WAIT_SPACE: load the address and go to REQ.
- The first word after a redirect with redirect_pc[1] = 1 carries ex_skip_lo = 1; all other words carry 0.
- FLUSH with mem_ack: no push; go to REQ with the pending target address.

Decomposition:
- Shared package: fetch state encoding (IDLE, REQ, WAIT_SPACE, FLUSH); INST_W = 16; WORD_W = 32; FETCH_STRIDE = 4.
- Sub-module fetch_skid_fifo: DEPTH x 33 bits (word + skip tag), with synchronous clear, count output, and combined push/pop.

Test Plan:
- Reset release, RESET_PC = 0, memory acks 2 cycles after each req, buf_full = 0 → mem_addr sequence 0, 4, 8; write pulses carry mem_rdata in order; ex_skip_lo = 0.
- buf_full held high, words 32'hA1A0_B1B0 and 32'hC1C0_D1D0 acked → FIFO fills, mem_req drops (WAIT_SPACE) after 2 words; release buf_full → both words emitted in order on consecutive cycles, then mem_req re-asserts at addr 8.
- Redirect to 32'h0000_0102 while the request at addr 4 is outstanding → mem_addr stays 4 until ack; that data is never written; next mem_addr = 32'h100; first write has ex_skip_lo = 1, second has 0.
- Redirect in the same cycle as mem_ack → acked word dropped, FIFO emptied, write = 0 that cycle, next request at the redirect word address.
- RESET_PC = 32'hFFFF_FFFC, two fetches → mem_addr 32'hFFFF_FFFC then 32'h0000_0000.
- Async rst asserted mid-WAIT_SPACE with a full FIFO → outputs return to reset values immediately without a clock; after release, fetch restarts at RESET_PC.
